// File: rtl/wb_merge_unit.sv
// Write-back merge stage: arbitrates the single register-file write port between
// the pipeline WB slot and a small FIFO of long-latency results.
module wb_merge_unit #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      PipeWrEn_i,
    input  logic [4:0]                PipeWrReg_i,
    input  logic [31:0]               PipeWrData_i,
    input  logic                      LlValid_i,
    output logic                      LlReady_o,
    input  logic [4:0]                LlWrReg_i,
    input  logic [31:0]               LlWrData_i,
    output logic                      RegWrEn_o,
    output logic [4:0]                WriteReg_o,
    output logic [31:0]               WriteData_o,
    output logic                      Stall_o,
    output logic [31:0]               PendingRegMask_o,
    output logic [$clog2(DEPTH):0]    Pending_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       regQ  [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [DEPTH-1:0] liveQ;
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    waitCnt;
    logic [WW-1:0]    waitNext;
    logic             stallQ;

    logic slotBusy;
    logic empty;
    logic headLive;
    logic accept;
    logic bypass;
    logic push;
    logic pop;
    logic pushLive;

    assign slotBusy  = PipeWrEn_i && (PipeWrReg_i != 5'd0);
    assign empty     = (count == '0);
    assign headLive  = !empty && liveQ[rdPtr];
    assign LlReady_o = (count < CW'(DEPTH));
    assign accept    = LlValid_i && LlReady_o;
    assign bypass    = !slotBusy && empty && accept && (LlWrReg_i != 5'd0);
    assign push      = accept && (LlWrReg_i != 5'd0) && !bypass;
    // A killed head leaves regardless of the slot; a live one only in an idle slot.
    assign pop       = !empty && (!liveQ[rdPtr] || !slotBusy);
    // The LL value is always older than a same-cycle pipeline write to the same reg.
    assign pushLive  = !(slotBusy && (LlWrReg_i == PipeWrReg_i));

    assign Stall_o   = stallQ;
    assign Pending_o = count;

    always_comb begin
        RegWrEn_o   = 1'b0;
        WriteReg_o  = 5'd0;
        WriteData_o = 32'd0;
        if (slotBusy) begin
            RegWrEn_o   = 1'b1;
            WriteReg_o  = PipeWrReg_i;
            WriteData_o = PipeWrData_i;
        end else if (headLive) begin
            RegWrEn_o   = 1'b1;
            WriteReg_o  = regQ[rdPtr];
            WriteData_o = dataQ[rdPtr];
        end else if (bypass) begin
            RegWrEn_o   = 1'b1;
            WriteReg_o  = LlWrReg_i;
            WriteData_o = LlWrData_i;
        end
    end

    always_comb begin
        PendingRegMask_o = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveQ[i]) begin
                PendingRegMask_o[regQ[i]] = 1'b1;
            end
        end
        PendingRegMask_o[0] = 1'b0;
    end

    always_comb begin
        waitNext = '0;
        if (headLive && !pop) begin
            waitNext = (waitCnt >= WW'(MAX_WAIT)) ? WW'(MAX_WAIT) : waitCnt + WW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                regQ[i]  <= 5'd0;
                dataQ[i] <= 32'd0;
            end
            liveQ   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            waitCnt <= '0;
            stallQ  <= 1'b0;
        end else begin
            if (slotBusy) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (regQ[i] == PipeWrReg_i) begin
                        liveQ[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                liveQ[rdPtr] <= 1'b0;
                rdPtr        <= rdPtr + AW'(1);
            end
            if (push) begin
                regQ[wrPtr]  <= LlWrReg_i;
                dataQ[wrPtr] <= LlWrData_i;
                liveQ[wrPtr] <= pushLive;
                wrPtr        <= wrPtr + AW'(1);
            end
            count   <= count + CW'(push) - CW'(pop);
            waitCnt <= waitNext;
            stallQ  <= (waitNext >= WW'(MAX_WAIT));
        end
    end

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_wb_merge_unit;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        pipeWrEn;
    logic [4:0]  pipeWrReg;
    logic [31:0] pipeWrData;
    logic        llValid;
    logic        llReady;
    logic [4:0]  llWrReg;
    logic [31:0] llWrData;
    logic        regWrEn;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        stall;
    logic [31:0] pendingRegMask;
    logic [1:0]  pending;

    int nVectors = 0;
    int nMiscompares = 0;

    wb_merge_unit #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .PipeWrEn_i(pipeWrEn),
        .PipeWrReg_i(pipeWrReg),
        .PipeWrData_i(pipeWrData),
        .LlValid_i(llValid),
        .LlReady_o(llReady),
        .LlWrReg_i(llWrReg),
        .LlWrData_i(llWrData),
        .RegWrEn_o(regWrEn),
        .WriteReg_o(writeReg),
        .WriteData_o(writeData),
        .Stall_o(stall),
        .PendingRegMask_o(pendingRegMask),
        .Pending_o(pending)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        @(posedge clk_i);
        #1;
        pipeWrEn   = pe;
        pipeWrReg  = pr;
        pipeWrData = pd;
        llValid    = lv;
        llWrReg    = lr;
        llWrData   = ld;
        #2;
    endtask

    // Reference model: FIFO as a queue of {dest, data, live}, evaluated before each edge.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } entry_t;

    entry_t q[$];
    int     waitM = 0;
    bit     stallM = 0;

    always @(negedge clk_i) begin : compareProc
        bit          busy, ready, acc, headLive, byp, doPop;
        logic        expEn;
        logic [4:0]  expReg;
        logic [31:0] expData, expMask;
        entry_t      e;
        if (!rst_ni) begin
            q.delete();
            waitM  = 0;
            stallM = 0;
            checkOutput("rstRegWrEn", {31'd0, regWrEn}, 32'd0);
            checkOutput("rstPending", {30'd0, pending}, 32'd0);
            checkOutput("rstMask", pendingRegMask, 32'd0);
            checkOutput("rstStall", {31'd0, stall}, 32'd0);
            checkOutput("rstReady", {31'd0, llReady}, 32'd1);
        end else begin
            busy     = pipeWrEn && (pipeWrReg != 0);
            ready    = q.size() < DEPTH;
            acc      = llValid && ready;
            headLive = (q.size() > 0) && q[0].live;
            byp      = !busy && (q.size() == 0) && acc && (llWrReg != 0);
            expEn = 0; expReg = 0; expData = 0;
            if (busy) begin
                expEn = 1; expReg = pipeWrReg; expData = pipeWrData;
            end else if (headLive) begin
                expEn = 1; expReg = q[0].rd; expData = q[0].data;
            end else if (byp) begin
                expEn = 1; expReg = llWrReg; expData = llWrData;
            end
            expMask = 0;
            foreach (q[i]) if (q[i].live) expMask[q[i].rd] = 1'b1;
            expMask[0] = 1'b0;

            checkOutput("RegWrEn", {31'd0, regWrEn}, {31'd0, expEn});
            checkOutput("WriteReg", {27'd0, writeReg}, {27'd0, expReg});
            checkOutput("WriteData", writeData, expData);
            checkOutput("LlReady", {31'd0, llReady}, {31'd0, ready});
            checkOutput("Stall", {31'd0, stall}, {31'd0, stallM});
            checkOutput("PendingMask", pendingRegMask, expMask);
            checkOutput("Pending", {30'd0, pending}, q.size());

            doPop = (q.size() > 0) && (!q[0].live || !busy);
            if (busy) begin
                foreach (q[i]) begin
                    if (q[i].rd == pipeWrReg) begin
                        e = q[i]; e.live = 0; q[i] = e;
                    end
                end
            end
            if (doPop) void'(q.pop_front());
            if (acc && llWrReg != 0 && !byp) begin
                e.rd = llWrReg; e.data = llWrData;
                e.live = !(busy && llWrReg == pipeWrReg);
                q.push_back(e);
            end
            if (headLive && !doPop) waitM = (waitM >= MAX_WAIT) ? MAX_WAIT : waitM + 1;
            else waitM = 0;
            stallM = (waitM >= MAX_WAIT);
        end
    end

    initial begin
        rst_ni = 1'b0;
        pipeWrEn = 0; pipeWrReg = 0; pipeWrData = 0;
        llValid = 0; llWrReg = 0; llWrData = 0;
        @(posedge clk_i); #1;
        checkOutput("initRegWrEn", {31'd0, regWrEn}, 32'd0);
        checkOutput("initReady", {31'd0, llReady}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] bypass into idle slot");
        applyStimulus(0, 0, 0, 1, 5, 32'h1234);
        checkOutput("bypEn", {31'd0, regWrEn}, 32'd1);
        checkOutput("bypReg", {27'd0, writeReg}, 32'd5);
        checkOutput("bypData", writeData, 32'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bypPending", {30'd0, pending}, 32'd0);

        $display("[TB] starvation and stall");
        applyStimulus(1, 3, 32'h33, 1, 7, 32'hA);
        checkOutput("c0Reg", {27'd0, writeReg}, 32'd3);
        applyStimulus(1, 3, 32'h33, 1, 8, 32'hB);
        checkOutput("c1Pending", {30'd0, pending}, 32'd1);
        checkOutput("c1Ready", {31'd0, llReady}, 32'd1);
        applyStimulus(1, 3, 32'h33, 0, 0, 0);
        checkOutput("c2Ready", {31'd0, llReady}, 32'd0);
        checkOutput("c2Mask", pendingRegMask, 32'h0000_0180);
        applyStimulus(1, 3, 32'h33, 0, 0, 0);
        applyStimulus(1, 3, 32'h33, 0, 0, 0);
        checkOutput("c4Stall", {31'd0, stall}, 32'd0);
        applyStimulus(1, 3, 32'h33, 0, 0, 0);
        checkOutput("c5Stall", {31'd0, stall}, 32'd1);
        checkOutput("c5Reg", {27'd0, writeReg}, 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("c6Reg", {27'd0, writeReg}, 32'd7);
        checkOutput("c6Data", writeData, 32'hA);
        checkOutput("c6Stall", {31'd0, stall}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("c7Reg", {27'd0, writeReg}, 32'd8);
        checkOutput("c7Data", writeData, 32'hB);
        checkOutput("c7Stall", {31'd0, stall}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("c8Pending", {30'd0, pending}, 32'd0);

        $display("[TB] WAW kill");
        applyStimulus(1, 3, 32'h33, 1, 9, 32'h1);
        applyStimulus(1, 9, 32'h2, 0, 0, 0);
        checkOutput("wawData", writeData, 32'h2);
        checkOutput("wawMaskBefore", {31'd0, pendingRegMask[9]}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wawMaskAfter", pendingRegMask, 32'd0);
        checkOutput("wawSilent", {31'd0, regWrEn}, 32'd0);
        checkOutput("wawPending", {30'd0, pending}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wawDrained", {30'd0, pending}, 32'd0);

        $display("[TB] x0 handling");
        applyStimulus(1, 3, 32'h33, 1, 4, 32'h55);
        applyStimulus(1, 0, 32'hDEAD, 1, 0, 32'h77);
        checkOutput("x0SlotReg", {27'd0, writeReg}, 32'd4);
        checkOutput("x0SlotData", writeData, 32'h55);
        applyStimulus(0, 0, 0, 1, 0, 32'h77);
        checkOutput("x0LlEn", {31'd0, regWrEn}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("x0LlPending", {30'd0, pending}, 32'd0);

        $display("[TB] full with pop");
        applyStimulus(1, 3, 32'h33, 1, 10, 32'h10);
        applyStimulus(1, 3, 32'h33, 1, 11, 32'h11);
        applyStimulus(0, 0, 0, 1, 12, 32'h12);
        checkOutput("fullReady", {31'd0, llReady}, 32'd0);
        checkOutput("fullPopReg", {27'd0, writeReg}, 32'd10);
        applyStimulus(0, 0, 0, 1, 12, 32'h12);
        checkOutput("nextReady", {31'd0, llReady}, 32'd1);
        checkOutput("nextPopReg", {27'd0, writeReg}, 32'd11);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("lastReg", {27'd0, writeReg}, 32'd12);
        checkOutput("lastData", writeData, 32'h12);

        $display("[TB] pointer wrap");
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2) == 0, 5'd2, 32'h200 + k, 1'b1, 5'(16 + (k % 8)), 32'h100 + k);
        end
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset with pending entries");
        applyStimulus(1, 2, 32'h22, 1, 20, 32'h20);
        applyStimulus(1, 2, 32'h22, 1, 21, 32'h21);
        checkOutput("preRstPending", {30'd0, pending}, 32'd1);
        @(posedge clk_i); #1;
        pipeWrEn = 0; pipeWrReg = 0; pipeWrData = 0;
        llValid = 0; llWrReg = 0; llWrData = 0;
        rst_ni = 1'b0;
        #1;
        checkOutput("rstNowPending", {30'd0, pending}, 32'd0);
        checkOutput("rstNowMask", pendingRegMask, 32'd0);
        checkOutput("rstNowReady", {31'd0, llReady}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #2;
        checkOutput("postRstEn", {31'd0, regWrEn}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("postRstEn2", {31'd0, regWrEn}, 32'd0);
        checkOutput("postRstPending", {30'd0, pending}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        @(posedge clk_i); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
